// File: rtl/fault_campaign_if.sv
// Handshake and stimulus bundle between a fault campaign controller and the
// circuit-under-test harness.
//   master : drives start/abort and returns dut_y; observes all status
//   slave  : the controller; drives inj_*, fault_sel and status outputs
interface fault_campaign_if;
  logic       start;
  logic       abort;
  logic       dut_y;
  logic       inj_a;
  logic       inj_b;
  logic       inj_e;
  logic       inj_f;
  logic [2:0] fault_sel;
  logic       busy;
  logic       done;
  logic [5:0] det_mask;
  logic [2:0] det_count;
  logic [6:0] mism_count;

  modport master (
    output start, abort, dut_y,
    input  inj_a, inj_b, inj_e, inj_f, fault_sel, busy, done, det_mask, det_count, mism_count
  );

  modport slave (
    input  start, abort, dut_y,
    output inj_a, inj_b, inj_e, inj_f, fault_sel, busy, done, det_mask, det_count, mism_count
  );
endinterface

// File: rtl/fault_campaign_ctrl.sv
// Stuck-at fault campaign controller for the circuit y = (a|b) ^ (e|~f).
// Walks fault sites 0..5 (sig1 = a|b, sig2 = e|~f, y; SA0 then SA1 each) and
// exhaustive 4-bit vectors {a,b,e,f}, compares the faulty circuit's y against
// the golden value and records which faults were detected.
// Ports:
//   clk, rst : campaign clock, asynchronous active-high reset
//   bus      : slave side of fault_campaign_if
//              in : start (launch pulse), abort, dut_y (faulty circuit output)
//              out: inj_a/b/e/f, fault_sel (7 = none), busy, done,
//                   det_mask, det_count, mism_count (saturating at 127)
module fault_campaign_ctrl #(
  parameter int unsigned SETTLE     = 2,    // wait cycles between apply and sample (1..15)
  parameter bit          EARLY_EXIT = 1'b1  // retire a fault at its first detecting vector
) (
  input logic             clk,
  input logic             rst,
  fault_campaign_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StApply,
    StWait,
    StSample,
    StDone
  } state_e;

  localparam logic [2:0] FaultNone = 3'd7;
  localparam logic [2:0] FaultLast = 3'd5;

  state_e     state_q, state_d;
  logic [3:0] vec_q, vec_d;
  logic [2:0] fault_q, fault_d;
  logic [3:0] wait_q, wait_d;
  logic [3:0] inj_q, inj_d;
  logic [2:0] fsel_q, fsel_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [5:0] mask_q, mask_d;
  logic [2:0] cnt_q, cnt_d;
  logic [6:0] mism_q, mism_d;

  logic golden;
  logic mismatch;

  function automatic logic [2:0] popcount6(logic [5:0] m);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < 6; i++) begin
      c = c + {2'b00, m[i]};
    end
    return c;
  endfunction

  // vec_q[3:0] = {a,b,e,f}
  assign golden   = (vec_q[3] | vec_q[2]) ^ (vec_q[1] | ~vec_q[0]);
  assign mismatch = (bus.dut_y != golden);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    fault_d = fault_q;
    wait_d  = wait_q;
    inj_d   = inj_q;
    fsel_d  = fsel_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    mask_d  = mask_q;
    mism_d  = mism_q;

    if (bus.abort) begin
      // Abort beats start too; partial results are left untouched.
      state_d = StIdle;
      busy_d  = 1'b0;
      fsel_d  = FaultNone;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            mask_d  = '0;
            mism_d  = '0;
            fault_d = '0;
            vec_d   = '0;
            busy_d  = 1'b1;
            state_d = StApply;
          end
        end
        StApply: begin
          inj_d   = vec_q;
          fsel_d  = fault_q;
          wait_d  = '0;
          state_d = StWait;
        end
        StWait: begin
          if (wait_q == 4'(SETTLE - 1)) begin
            state_d = StSample;
          end else begin
            wait_d = wait_q + 4'd1;
          end
        end
        StSample: begin
          if (mismatch) begin
            mask_d = mask_q | (6'b000001 << fault_q);
            if (mism_q != 7'd127) begin
              mism_d = mism_q + 7'd1;
            end
          end
          if ((vec_q == 4'd15) || (EARLY_EXIT && mismatch)) begin
            vec_d = '0;
            if (fault_q == FaultLast) begin
              // busy drops as DONE is entered
              busy_d  = 1'b0;
              fsel_d  = FaultNone;
              state_d = StDone;
            end else begin
              fault_d = fault_q + 3'd1;
              state_d = StApply;
            end
          end else begin
            vec_d   = vec_q + 4'd1;
            state_d = StApply;
          end
        end
        StDone: begin
          done_d  = 1'b1;
          fsel_d  = FaultNone;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
          busy_d  = 1'b0;
          fsel_d  = FaultNone;
        end
      endcase
    end

    // Count tracks the mask on the same edge.
    cnt_d = popcount6(mask_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      vec_q   <= '0;
      fault_q <= '0;
      wait_q  <= '0;
      inj_q   <= '0;
      fsel_q  <= FaultNone;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mask_q  <= '0;
      cnt_q   <= '0;
      mism_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      fault_q <= fault_d;
      wait_q  <= wait_d;
      inj_q   <= inj_d;
      fsel_q  <= fsel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      mism_q  <= mism_d;
    end
  end

  assign bus.inj_a      = inj_q[3];
  assign bus.inj_b      = inj_q[2];
  assign bus.inj_e      = inj_q[1];
  assign bus.inj_f      = inj_q[0];
  assign bus.fault_sel  = fsel_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.det_mask   = mask_q;
  assign bus.det_count  = cnt_q;
  assign bus.mism_count = mism_q;

endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// Bench for fault_campaign_ctrl: two instances (EARLY_EXIT=0 and =1, SETTLE=2)
// each driving a behavioural faulty-circuit model. Campaign results are
// pushed to per-instance queues at start; a monitor pops on each done pulse.
module tb_fault_campaign_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fault_campaign_if bus0 ();
  fault_campaign_if bus1 ();

  fault_campaign_ctrl #(.SETTLE(2), .EARLY_EXIT(1'b0)) u_ee0 (
    .clk(clk),
    .rst(rst),
    .bus(bus0)
  );

  fault_campaign_ctrl #(.SETTLE(2), .EARLY_EXIT(1'b1)) u_ee1 (
    .clk(clk),
    .rst(rst),
    .bus(bus1)
  );

  // Fault sites that actually take effect in each circuit model.
  logic [5:0] live0 = 6'h3F;
  logic [5:0] live1 = 6'h3F;

  function automatic logic faulty_y(logic [3:0] v, logic [2:0] fs, logic [5:0] live);
    logic       s1, s2, y;
    logic [7:0] l8;
    l8 = {2'b00, live};
    s1 = v[3] | v[2];
    s2 = v[1] | ~v[0];
    if (l8[fs]) begin
      if (fs == 3'd0) s1 = 1'b0;
      if (fs == 3'd1) s1 = 1'b1;
      if (fs == 3'd2) s2 = 1'b0;
      if (fs == 3'd3) s2 = 1'b1;
    end
    y = s1 ^ s2;
    if (l8[fs] && fs == 3'd4) y = 1'b0;
    if (l8[fs] && fs == 3'd5) y = 1'b1;
    return y;
  endfunction

  assign bus0.dut_y = faulty_y({bus0.inj_a, bus0.inj_b, bus0.inj_e, bus0.inj_f},
                               bus0.fault_sel, live0);
  assign bus1.dut_y = faulty_y({bus1.inj_a, bus1.inj_b, bus1.inj_e, bus1.inj_f},
                               bus1.fault_sel, live1);

  typedef struct packed {
    logic [3:0] inj;
    logic [2:0] fsel;
    logic       busy;
    logic       done;
    logic [5:0] mask;
    logic [2:0] cnt;
    logic [6:0] mism;
  } obs_t;

  obs_t o0, o1;
  assign o0 = {bus0.inj_a, bus0.inj_b, bus0.inj_e, bus0.inj_f, bus0.fault_sel, bus0.busy,
               bus0.done, bus0.det_mask, bus0.det_count, bus0.mism_count};
  assign o1 = {bus1.inj_a, bus1.inj_b, bus1.inj_e, bus1.inj_f, bus1.fault_sel, bus1.busy,
               bus1.done, bus1.det_mask, bus1.det_count, bus1.mism_count};

  typedef struct {
    int mask;
    int cnt;
    int mism;
    int lat;
    int c0;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic obs_t obs(int which);
    return (which == 0) ? o0 : o1;
  endfunction

  function automatic int qsize(int which);
    return (which == 0) ? q0.size() : q1.size();
  endfunction

  task automatic check_reset(int which, string tag);
    obs_t o;
    o = obs(which);
    chk($sformatf("%s_u%0d_inj", tag, which), int'(o.inj), 0);
    chk($sformatf("%s_u%0d_fault_sel", tag, which), int'(o.fsel), 7);
    chk($sformatf("%s_u%0d_busy", tag, which), int'(o.busy), 0);
    chk($sformatf("%s_u%0d_done", tag, which), int'(o.done), 0);
    chk($sformatf("%s_u%0d_det_mask", tag, which), int'(o.mask), 0);
    chk($sformatf("%s_u%0d_det_count", tag, which), int'(o.cnt), 0);
    chk($sformatf("%s_u%0d_mism_count", tag, which), int'(o.mism), 0);
  endtask

  task automatic set_start(int which, logic v);
    if (which == 0) bus0.start = v;
    else bus1.start = v;
  endtask

  task automatic set_abort(int which, logic v);
    if (which == 0) bus0.abort = v;
    else bus1.abort = v;
  endtask

  // Called at a negedge; returns at the negedge after the start-sampling edge.
  task automatic launch(int which, output int c0);
    set_start(which, 1'b1);
    @(negedge clk);
    set_start(which, 1'b0);
    c0 = cyc;
    chk($sformatf("u%0d_busy_after_start", which), int'(obs(which).busy), 1);
  endtask

  task automatic go(int which, int mask, int cnt, int mism, int lat);
    exp_t e;
    int   c0;
    launch(which, c0);
    e.mask = mask;
    e.cnt  = cnt;
    e.mism = mism;
    e.lat  = lat;
    e.c0   = c0;
    if (which == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic wait_empty(int which, int budget);
    int n;
    n = 0;
    while (qsize(which) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("u%0d_done_within_budget", which), int'(qsize(which) == 0), 1);
    if (which == 0) q0.delete();
    else q1.delete();
  endtask

  task automatic mon(int which);
    obs_t o;
    exp_t e;
    o = obs(which);
    if (o.done === 1'b1) begin
      if (qsize(which) == 0) begin
        chk($sformatf("u%0d_spurious_done", which), int'(o.done), 0);
      end else begin
        if (which == 0) e = q0.pop_front();
        else e = q1.pop_front();
        chk($sformatf("u%0d_det_mask", which), int'(o.mask), e.mask);
        chk($sformatf("u%0d_det_count", which), int'(o.cnt), e.cnt);
        chk($sformatf("u%0d_mism_count", which), int'(o.mism), e.mism);
        chk($sformatf("u%0d_done_latency", which), cyc - e.c0, e.lat);
        chk($sformatf("u%0d_busy_at_done", which), int'(o.busy), 0);
        chk($sformatf("u%0d_fault_sel_at_done", which), int'(o.fsel), 7);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0);
      mon(1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cyc=%0d)", cyc);
    $fatal(1);
  end

  initial begin
    int c0;
    bus0.start = 1'b0;
    bus0.abort = 1'b0;
    bus1.start = 1'b0;
    bus1.abort = 1'b0;

    repeat (3) @(negedge clk);
    check_reset(0, "por");
    check_reset(1, "por");

    // Start on the very first edge after reset release.
    rst = 1'b0;
    go(1, 'h3F, 6, 6, 49);
    wait_empty(1, 200);

    // Full exhaustive campaign: 12+4+12+4+6+10 mismatches.
    @(negedge clk);
    go(0, 'h3F, 6, 48, 385);
    wait_empty(0, 600);

    // Faults never take effect.
    live0 = 6'h00;
    @(negedge clk);
    go(0, 0, 0, 0, 385);
    wait_empty(0, 600);
    live0 = 6'h3F;

    // start while busy is ignored: latency and results unchanged.
    @(negedge clk);
    go(1, 'h3F, 6, 6, 49);
    repeat (10) @(negedge clk);
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    chk("u1_busy_after_ignored_start", int'(o1.busy), 1);
    wait_empty(1, 200);

    // start and abort together in IDLE: abort wins.
    @(negedge clk);
    bus1.start = 1'b1;
    bus1.abort = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    bus1.abort = 1'b0;
    chk("idle_abort_busy", int'(o1.busy), 0);
    chk("idle_abort_mask_kept", int'(o1.mask), 'h3F);
    chk("idle_abort_mism_kept", int'(o1.mism), 6);
    repeat (10) @(negedge clk);
    chk("idle_abort_still_idle", int'(o1.busy), 0);

    // Abort during fault 2, vector 5; only faults 0 and 1 are observable.
    live0 = 6'h03;
    launch(0, c0);
    while (cyc - c0 < 150) @(negedge clk);
    chk("pre_abort_fault_sel", int'(o0.fsel), 2);
    chk("pre_abort_inj", int'(o0.inj), 5);
    set_abort(0, 1'b1);
    @(negedge clk);
    set_abort(0, 1'b0);
    chk("abort_busy", int'(o0.busy), 0);
    chk("abort_done", int'(o0.done), 0);
    chk("abort_fault_sel", int'(o0.fsel), 7);
    chk("abort_det_mask", int'(o0.mask), 'h03);
    chk("abort_det_count", int'(o0.cnt), 2);
    chk("abort_mism_count", int'(o0.mism), 16);
    repeat (20) @(negedge clk);
    chk("abort_mask_held", int'(o0.mask), 'h03);
    chk("abort_mism_held", int'(o0.mism), 16);
    chk("abort_busy_held", int'(o0.busy), 0);
    live0 = 6'h3F;

    // Reset pulse mid-WAIT, then a full early-exit campaign.
    launch(1, c0);
    repeat (9) @(negedge clk);
    chk("pre_rst_busy", int'(o1.busy), 1);
    rst = 1'b1;
    #1;
    check_reset(1, "async_rst");
    check_reset(0, "async_rst");
    @(negedge clk);
    rst = 1'b0;
    go(1, 'h3F, 6, 6, 49);
    wait_empty(1, 200);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fault_campaign_ctrl.md
FAULT_CAMPAIGN_CTRL -- requirements
Module: fault_campaign_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset: ports clk and rst.
REQ-002 Parameter SETTLE, default 2: number of wait cycles (1..15) between applying a vector and sampling the DUT output.
REQ-003 Parameter EARLY_EXIT, default 1: when 1, a fault is retired at its first detecting vector.
REQ-004 clk  input  1  campaign clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 start  input  1  a one-cycle pulse that launches a campaign; ignored while busy=1.
REQ-007 abort  input  1  stops the campaign and returns to IDLE; has priority over every other transition.
REQ-008 dut_y  input  1  output y of the faulty circuit instance.
REQ-009 inj_a, inj_b, inj_e, inj_f  output  1 each  registered stimulus; vector index v[3:0] maps as {a,b,e,f} = v[3:0].
REQ-010 fault_sel  output  3  active fault site: 0=sig1 SA0, 1=sig1 SA1, 2=sig2 SA0, 3=sig2 SA1, 4=y SA0, 5=y SA1, 7=none.
REQ-011 busy  output  1  high from the cycle after start is accepted until the cycle DONE is entered.
REQ-012 done  output  1  a one-cycle completion pulse.
REQ-013 det_mask  output  6  bit k high means fault k was detected.
REQ-014 det_count  output  3  popcount of det_mask.
REQ-015 mism_count  output  7  total mismatching samples in the campaign; saturates at 127.

Function
REQ-016 The block SHALL implement the states IDLE, APPLY, WAIT, SAMPLE and DONE.
REQ-017 IDLE: on start=1, clear det_mask, det_count and mism_count, set the fault index to 0 and the vector index to 0, then go to APPLY.
REQ-018 APPLY (1 cycle): drive inj_* from the vector index and fault_sel from the fault index, then go to WAIT.
REQ-019 WAIT: stay for exactly SETTLE cycles, then go to SAMPLE.
REQ-020 SAMPLE (1 cycle): compute golden = (a|b) ^ (e|~f) from the current vector and compare it with dut_y.
REQ-021 On a mismatch in SAMPLE: set det_mask[fault] and increment mism_count with saturation.
REQ-022 Next-step rule after SAMPLE: if vector=15, or EARLY_EXIT=1 and a mismatch occurred, set vector to 0 and advance the fault index; otherwise increment the vector index.
REQ-023 After fault 5 completes, go to DONE; otherwise go to APPLY.
REQ-024 DONE (1 cycle): assert done, set fault_sel=7 and busy=0, then go to IDLE.
REQ-025 Each vector SHALL take exactly SETTLE+2 cycles.
REQ-026 With EARLY_EXIT=0, done SHALL assert 96*(SETTLE+2)+1 cycles after the edge that samples start.
REQ-027 start asserted in DONE or while busy=1 SHALL be ignored; start is honoured only in IDLE.
REQ-028 abort in any state other than IDLE SHALL, on the next edge: enter IDLE, set busy=0 and fault_sel=7, and not pulse done.
REQ-029 After abort, det_mask and mism_count SHALL hold their partial values until the next start.
REQ-030 Simultaneous start and abort in IDLE: abort wins and the block stays in IDLE.
REQ-031 dut_y SHALL be sampled only in SAMPLE; its value in every other state has no effect.
REQ-032 det_count SHALL be updated in the same cycle as det_mask.
REQ-033 inj_* SHALL hold their values through WAIT and SAMPLE.

Reset
REQ-034 While rst=1, asynchronously: state=IDLE, inj_*=0, fault_sel=7, busy=0, done=0, det_mask=0, det_count=0, mism_count=0, and both indices=0.
REQ-035 Reset asserted mid-campaign SHALL abandon the campaign with no done pulse.
REQ-036 The first start SHALL be accepted on the first edge after rst deasserts.

Verification
REQ-037 Correct DUT, EARLY_EXIT=0, SETTLE=2 -> done 385 cycles after start; det_mask=6'h3F; det_count=6; mism_count=48 (12,4,12,4,6,10 per fault).
REQ-038 Correct DUT, EARLY_EXIT=1, SETTLE=2 -> first detecting vectors are 4,0,0,1,0,1; 12 vectors applied; mism_count=6; done 49 cycles after start.
REQ-039 dut_y tied to the golden model (fault never takes effect) -> det_mask=0, det_count=0, mism_count=0, done pulses once.
REQ-040 Abort during fault 2, vector 5 -> busy=0 next cycle; no done; det_mask=6'h03 held; fault_sel=7.
REQ-041 rst pulse mid-WAIT, then start -> all outputs at reset values, then a full campaign matching REQ-038.
REQ-042 start pulsed while busy=1, and start and abort together in IDLE -> no restart, no state change, no done.
